// File: rtl/top_blink.sv
// Gated LED blinker: a synchronized enable input starts a blink burst on the
// registered output y, and y is forced low while the enable is low.
// Every burst begins with y ON, followed by alternating HALF_PERIOD-long levels.
module top_blink #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BLINK_HZ    = 1,
    parameter int HALF_PERIOD = CLK_FREQ_HZ / (2 * BLINK_HZ),
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y
);

    // A HALF_PERIOD of 1 still needs a one-bit counter, so the width never drops to 0.
    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_a_d;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_y;

    logic w_a_s;
    logic w_rise;

    assign w_a_s  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_a_s & ~r_a_d;
    assign y      = r_y;

    // Shift the asynchronous enable through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a};
        end
    end

    // Remember the previous synchronized enable so a new burst can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_d <= 1'b0;
        end else begin
            r_a_d <= w_a_s;
        end
    end

    // Half-period counter and LED level; a fresh enable always restarts with y ON.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_y   <= 1'b0;
        end else if (!w_a_s) begin
            r_cnt <= '0;
            r_y   <= 1'b0;
        end else if (w_rise) begin
            r_cnt <= '0;
            r_y   <= 1'b1;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_y   <= ~r_y;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_top_blink.sv
// Directed bench for top_blink: reset, enable latency, blink waveform,
// disable/re-enable mid-burst, asynchronous reset mid-burst, HALF_PERIOD=1.
module tb_top_blink;

    logic clk;
    logic rst_n;
    logic a;
    logic y;
    logic y1;

    int n_checks;
    int n_pass;
    int rises;
    logic prev_y;
    logic exp_y;

    top_blink #(
        .HALF_PERIOD(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .y    (y)
    );

    top_blink #(
        .HALF_PERIOD(1),
        .SYNC_STAGES(2)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .y    (y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        a        = 1'b0;

        // Reset asserted with a=1: y low immediately and throughout.
        #2;
        a     = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {7'd0, y}, 8'd0);
        check("reset_immediate_hp1", {7'd0, y1}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_hold", {7'd0, y}, 8'd0);
        end
        a = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_low", {7'd0, y}, 8'd0);
        end
        check("idle_cnt", 8'(dut.r_cnt), 8'd0);

        // Enable latency: y rises at the third edge after a rises.
        a = 1'b1;
        tick();
        check("lat_E0", {7'd0, y}, 8'd0);
        tick();
        check("lat_E1", {7'd0, y}, 8'd0);
        tick();
        check("lat_E2", {7'd0, y}, 8'd1);
        check("lat_E2_hp1", {7'd0, y1}, 8'd1);

        // Blink waveform: index 0 is the sample after E2; 4 high, 4 low, repeat.
        rises  = 1;
        prev_y = y;
        for (int idx = 1; idx < 40; idx++) begin
            tick();
            exp_y = ((idx / 4) % 2) == 0;
            check("blink", {7'd0, y}, {7'd0, exp_y});
            check("blink_hp1", {7'd0, y1}, {7'd0, ((idx % 2) == 0)});
            if (y && !prev_y) rises++;
            prev_y = y;
        end
        check("blink_rises", 8'(rises), 8'd5);

        // Disable mid-burst: y still high through the sync delay, low on the 3rd edge.
        tick();
        check("pre_disable_high", {7'd0, y}, 8'd1);
        a = 1'b0;
        tick();
        check("dis_E0", {7'd0, y}, 8'd1);
        tick();
        check("dis_E1", {7'd0, y}, 8'd1);
        tick();
        check("dis_E2", {7'd0, y}, 8'd0);
        check("dis_cnt", 8'(dut.r_cnt), 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dis_hold", {7'd0, y}, 8'd0);
            check("dis_hold_hp1", {7'd0, y1}, 8'd0);
            check("dis_hold_cnt", 8'(dut.r_cnt), 8'd0);
        end

        // Re-enable: a full ON half-period again, then low.
        a = 1'b1;
        tick();
        check("ren_E0", {7'd0, y}, 8'd0);
        tick();
        check("ren_E1", {7'd0, y}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ren_high", {7'd0, y}, 8'd1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ren_low", {7'd0, y}, 8'd0);
        end
        tick();
        check("ren_high_again", {7'd0, y}, 8'd1);

        // Asynchronous reset between edges while y is high.
        #2;
        check("arst_before", {7'd0, y}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("arst_immediate", {7'd0, y}, 8'd0);
        check("arst_cnt", 8'(dut.r_cnt), 8'd0);
        tick();
        check("arst_hold", {7'd0, y}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_E0", {7'd0, y}, 8'd0);
        tick();
        check("rel_E1", {7'd0, y}, 8'd0);
        tick();
        check("rel_E2", {7'd0, y}, 8'd1);
        check("rel_E2_hp1", {7'd0, y1}, 8'd1);
        tick();
        check("rel_E3", {7'd0, y}, 8'd1);
        check("rel_E3_hp1", {7'd0, y1}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
